rob: RTL
========

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 16, number of ROB entries (power of two, >= 4).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 alloc_x / alloc_y / alloc_z  input  1 each  allocate request per rename slot, program order x<y<z.
REQ-005 RegWr_in_x/y/z  input  1 each  instruction writes a destination register.
REQ-006 Pw_in_x/y/z  input  5 each  destination physical register.
REQ-007 rob_ready  output  1  at least 3 free entries; allocation accepted only when high.
REQ-008 rob_idx_x/y/z  output  log2(DEPTH) each  entry index assigned to each slot this cycle.
REQ-009 wb_valid_0..2  input  1 each  execution-unit completion ports.
REQ-010 wb_idx_0..2  input  log2(DEPTH) each  completing entry; wb_exp_0..2  input  1 each  instruction raised exception.
REQ-011 RegWr_x/y/z  output  1 each  committed slot updates architectural mapping.
REQ-012 exp_x/y/z  output  1 each  committed slot is the excepting instruction.
REQ-013 Pw_commit_x/y/z  output  5 each  physical register of committed slot.
REQ-014 flush  output  1  precise-exception flush pulse.
REQ-015 commit_cnt  output  32  committed-instruction count (see Configuration).

Function
REQ-016 Entry fields: valid, done, exp, RegWr, Pw; circular buffer with head (oldest), tail, count (0..DEPTH).
REQ-017 Allocation: when rob_ready and any alloc_k, requesting slots packed into consecutive entries from tail in x,y,z order; tail and count advance by number of requests.
REQ-018 rob_idx_k combinationally = tail + number of lower-order requesting slots; value meaningless when alloc_k low.
REQ-019 rob_ready = (DEPTH - count) >= 3, computed from registered count only.
REQ-020 Allocation with rob_ready low is ignored; no state change from alloc inputs.
REQ-021 Writeback: wb_valid_n sets done and loads exp of entry wb_idx_n at next edge; writeback to invalid entry ignored; distinct wb_idx values guaranteed by issue.
REQ-022 Commit is combinational from registered state: slot x = head, y = head+1, z = head+2; slot k commits iff entry valid and done and all older slots commit and no older slot has exp.
REQ-023 Committing non-exception slot: RegWr_k = entry RegWr, exp_k = 0, Pw_commit_k = entry Pw.
REQ-024 Committing exception slot: exp_k = 1, RegWr_k = 0, Pw_commit_k = entry Pw; younger slots do not commit; flush = 1 same cycle.
REQ-025 Non-committing slots drive RegWr_k = 0, exp_k = 0, Pw_commit_k = 0.
REQ-026 Head advances and count decreases by commit count at edge; committed entries cleared to invalid.
REQ-027 Commit and allocation in same cycle: count_next = count + allocated - committed.
REQ-028 Writeback to an entry in same cycle it commits cannot occur (commit requires done already registered).
REQ-029 flush: at next edge all entries invalid, head = tail = 0, count = 0; allocation and writeback in flush cycle discarded.
REQ-030 Pointers wrap modulo DEPTH; full/empty distinguished by count, never by pointer equality.

Reset
REQ-031 On rst: all entries invalid/not done, head = tail = count = 0, commit_cnt = 0.
REQ-032 Outputs during and after reset: rob_ready = 1, all RegWr_k/exp_k/Pw_commit_k = 0, flush = 0.
REQ-033 rst mid-operation overrides allocation, writeback and commit in that cycle.

Configuration
REQ-034 Macro ROB_COMMIT_CNT_EN defined: commit_cnt increments by number of committed slots per cycle (exception slot counted), wraps at 2^32.
REQ-035 Macro undefined: counter logic absent, commit_cnt tied to 0.

Verification
REQ-036 Reset, allocate x,y,z (Pw 5,6,7, RegWr 1) -> rob_idx 0,1,2; count 3; no commit until writeback.
REQ-037 Writeback idx 2 then idx 0,1 next cycle -> single cycle after: RegWr_x/y/z = 1, Pw_commit 5,6,7; count 0.
REQ-038 Entries 0..2 done, entry 1 wb_exp = 1 -> x commits normal, exp_y = 1, RegWr_y = 0, z silent, flush = 1; next cycle count 0, rob_ready 1.
REQ-039 Fill to count 14 -> rob_ready 0; alloc ignored; one commit -> count 13, rob_ready 1.
REQ-040 Run 40 alloc/commit pairs with DEPTH 16 -> indices wrap 15->0, Pw order preserved, no loss.
REQ-041 With ROB_COMMIT_CNT_EN, commit 7 instructions -> commit_cnt = 7; without macro -> 0.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: 3-wide in-order allocate, 3 writeback ports, 3-wide in-order commit.
// Optional committed-instruction counter enabled by macro ROB_COMMIT_CNT_EN.
module rob #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_x,
  input  logic                     alloc_y,
  input  logic                     alloc_z,
  input  logic                     RegWr_in_x,
  input  logic                     RegWr_in_y,
  input  logic                     RegWr_in_z,
  input  logic [4:0]               Pw_in_x,
  input  logic [4:0]               Pw_in_y,
  input  logic [4:0]               Pw_in_z,
  output logic                     rob_ready,
  output logic [$clog2(DEPTH)-1:0] rob_idx_x,
  output logic [$clog2(DEPTH)-1:0] rob_idx_y,
  output logic [$clog2(DEPTH)-1:0] rob_idx_z,
  input  logic                     wb_valid_0,
  input  logic                     wb_valid_1,
  input  logic                     wb_valid_2,
  input  logic [$clog2(DEPTH)-1:0] wb_idx_0,
  input  logic [$clog2(DEPTH)-1:0] wb_idx_1,
  input  logic [$clog2(DEPTH)-1:0] wb_idx_2,
  input  logic                     wb_exp_0,
  input  logic                     wb_exp_1,
  input  logic                     wb_exp_2,
  output logic                     RegWr_x,
  output logic                     RegWr_y,
  output logic                     RegWr_z,
  output logic                     exp_x,
  output logic                     exp_y,
  output logic                     exp_z,
  output logic [4:0]               Pw_commit_x,
  output logic [4:0]               Pw_commit_y,
  output logic [4:0]               Pw_commit_z,
  output logic                     flush,
  output logic [31:0]              commit_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef logic [IW-1:0] idx_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] exp_q, exp_d;
  logic [DEPTH-1:0] rw_q, rw_d;
  logic [4:0]       pw_q [DEPTH];
  logic [4:0]       pw_d [DEPTH];
  idx_t             head_q, head_d;
  idx_t             tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic       al   [3];
  logic       al_rw[3];
  logic [4:0] al_pw[3];
  idx_t       al_ix[3];
  logic       wbv  [3];
  idx_t       wbi  [3];
  logic       wbe  [3];
  idx_t       cm_ix[3];
  logic       cm   [3];
  logic [1:0] n_alloc, n_commit;
  logic       do_alloc;

  assign al[0]    = alloc_x;
  assign al[1]    = alloc_y;
  assign al[2]    = alloc_z;
  assign al_rw[0] = RegWr_in_x;
  assign al_rw[1] = RegWr_in_y;
  assign al_rw[2] = RegWr_in_z;
  assign al_pw[0] = Pw_in_x;
  assign al_pw[1] = Pw_in_y;
  assign al_pw[2] = Pw_in_z;
  assign wbv[0]   = wb_valid_0;
  assign wbv[1]   = wb_valid_1;
  assign wbv[2]   = wb_valid_2;
  assign wbi[0]   = wb_idx_0;
  assign wbi[1]   = wb_idx_1;
  assign wbi[2]   = wb_idx_2;
  assign wbe[0]   = wb_exp_0;
  assign wbe[1]   = wb_exp_1;
  assign wbe[2]   = wb_exp_2;

  // Ready looks only at the registered count, never at this cycle's commits.
  assign rob_ready = (CW'(DEPTH) - count_q) >= CW'(3);

  assign al_ix[0] = tail_q;
  assign al_ix[1] = tail_q + idx_t'(alloc_x);
  assign al_ix[2] = tail_q + idx_t'(alloc_x) + idx_t'(alloc_y);
  assign rob_idx_x = al_ix[0];
  assign rob_idx_y = al_ix[1];
  assign rob_idx_z = al_ix[2];

  assign n_alloc  = 2'(alloc_x) + 2'(alloc_y) + 2'(alloc_z);
  assign do_alloc = rob_ready & (alloc_x | alloc_y | alloc_z);

  assign cm_ix[0] = head_q;
  assign cm_ix[1] = head_q + idx_t'(1);
  assign cm_ix[2] = head_q + idx_t'(2);

  // An older exception blocks every younger slot.
  assign cm[0] = valid_q[cm_ix[0]] & done_q[cm_ix[0]];
  assign cm[1] = cm[0] & ~exp_q[cm_ix[0]]
               & valid_q[cm_ix[1]] & done_q[cm_ix[1]];
  assign cm[2] = cm[1] & ~exp_q[cm_ix[1]]
               & valid_q[cm_ix[2]] & done_q[cm_ix[2]];

  assign n_commit = 2'(cm[0]) + 2'(cm[1]) + 2'(cm[2]);

  assign flush = (cm[0] & exp_q[cm_ix[0]])
               | (cm[1] & exp_q[cm_ix[1]])
               | (cm[2] & exp_q[cm_ix[2]]);

  assign exp_x = cm[0] & exp_q[cm_ix[0]];
  assign exp_y = cm[1] & exp_q[cm_ix[1]];
  assign exp_z = cm[2] & exp_q[cm_ix[2]];

  assign RegWr_x = cm[0] & rw_q[cm_ix[0]] & ~exp_q[cm_ix[0]];
  assign RegWr_y = cm[1] & rw_q[cm_ix[1]] & ~exp_q[cm_ix[1]];
  assign RegWr_z = cm[2] & rw_q[cm_ix[2]] & ~exp_q[cm_ix[2]];

  assign Pw_commit_x = cm[0] ? pw_q[cm_ix[0]] : 5'd0;
  assign Pw_commit_y = cm[1] ? pw_q[cm_ix[1]] : 5'd0;
  assign Pw_commit_z = cm[2] ? pw_q[cm_ix[2]] : 5'd0;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exp_d   = exp_q;
    rw_d    = rw_q;
    pw_d    = pw_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      exp_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cm[k]) begin
          valid_d[cm_ix[k]] = 1'b0;
          done_d[cm_ix[k]]  = 1'b0;
          exp_d[cm_ix[k]]   = 1'b0;
        end
      end
      for (int n = 0; n < 3; n++) begin
        if (wbv[n] && valid_q[wbi[n]]) begin
          done_d[wbi[n]] = 1'b1;
          exp_d[wbi[n]]  = wbe[n];
        end
      end
      if (do_alloc) begin
        for (int k = 0; k < 3; k++) begin
          if (al[k]) begin
            valid_d[al_ix[k]] = 1'b1;
            done_d[al_ix[k]]  = 1'b0;
            exp_d[al_ix[k]]   = 1'b0;
            rw_d[al_ix[k]]    = al_rw[k];
            pw_d[al_ix[k]]    = al_pw[k];
          end
        end
        tail_d = tail_q + idx_t'(n_alloc);
      end
      head_d  = head_q + idx_t'(n_commit);
      count_d = count_q + (do_alloc ? CW'(n_alloc) : CW'(0))
              - CW'(n_commit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      exp_q   <= '0;
      rw_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
      rw_q    <= rw_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pw_q <= pw_d;
  end

`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 32'(n_commit);
  end

  assign commit_cnt = cnt_q;
`else
  assign commit_cnt = '0;
`endif

endmodule
